// File: rtl/carregador_matrizes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkg_matrizes: shared dimensions and loader states for the 5x5 int8 datapath
// rev 1.0
// ---------------------------------------------------------------------------
package pkg_matrizes;
  localparam int N     = 5;
  localparam int W     = 8;
  localparam int VEC_W = N * N * W;
  localparam int IDX_W = $clog2(N * N);

  localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(N * N - 1);

  typedef enum logic [1:0] {
    RECEBE_A = 2'd0,
    RECEBE_B = 2'd1,
    PRONTO   = 2'd2
  } estado_t;
endpackage
`default_nettype wire

// File: rtl/carregador_matrizes_registrador.sv
`default_nettype none
// ---------------------------------------------------------------------------
// registrador_matriz: linearized NxN element store, one element written per cycle
// rev 1.0
// ---------------------------------------------------------------------------
module registrador_matriz
  import pkg_matrizes::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     data,
  output logic [VEC_W-1:0] q
);

  logic [VEC_W-1:0] q_q;
  logic [VEC_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d[int'(idx) * W +: W] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/carregador_matrizes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// carregador_matrizes: byte-stream loader assembling A then B for the multiplier
// rev 1.0
// ---------------------------------------------------------------------------
module carregador_matrizes
  import pkg_matrizes::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [VEC_W-1:0] A,
  output logic [VEC_W-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             erro_sync
);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             erro_sync_q, erro_sync_d;
  logic             we_a, we_b;
  logic [IDX_W-1:0] idx_wr;
  logic             aceita;

  assign in_ready  = (estado_q != PRONTO);
  assign out_valid = (estado_q == PRONTO);
  assign erro_sync = erro_sync_q;
  assign aceita    = in_valid && in_ready;

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    erro_sync_d = 1'b0;
    we_a        = 1'b0;
    we_b        = 1'b0;
    idx_wr      = idx_q;

    if (aceita && in_first) begin
      // Resync: the marked byte is always A[0][0], wherever we were in the frame.
      we_a        = 1'b1;
      idx_wr      = '0;
      idx_d       = IDX_W'(1);
      estado_d    = RECEBE_A;
      erro_sync_d = !((estado_q == RECEBE_A) && (idx_q == '0));
    end else if (aceita) begin
      we_a = (estado_q == RECEBE_A);
      we_b = (estado_q == RECEBE_B);
      if (idx_q == IDX_ULTIMO) begin
        idx_d    = '0;
        estado_d = (estado_q == RECEBE_A) ? RECEBE_B : PRONTO;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if ((estado_q == PRONTO) && out_ready) begin
      estado_d = RECEBE_A;
      idx_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= RECEBE_A;
      idx_q       <= '0;
      erro_sync_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      erro_sync_q <= erro_sync_d;
    end
  end

  registrador_matriz u_reg_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a),
    .idx   (idx_wr),
    .data  (in_data),
    .q     (A)
  );

  registrador_matriz u_reg_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b),
    .idx   (idx_wr),
    .data  (in_data),
    .q     (B)
  );

endmodule
`default_nettype wire

// File: tb/tb_carregador_matrizes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_carregador_matrizes: directed bench for the matrix loader
// rev 1.0
// ---------------------------------------------------------------------------
module tb_carregador_matrizes;
  import pkg_matrizes::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_first = 1'b0;
  logic             in_ready;
  logic [VEC_W-1:0] A;
  logic [VEC_W-1:0] B;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             erro_sync;

  int checks = 0;
  int errors = 0;

  logic [VEC_W-1:0] exp_a, exp_b, tmp_a, bnd_a, bnd_b;

  carregador_matrizes dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .erro_sync (erro_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the byte accepted.
  task automatic push(input logic [W-1:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  function automatic logic [W-1:0] elem(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input int k);
    if (k < N * N) return a[k * W +: W];
    return b[(k - N * N) * W +: W];
  endfunction

  task automatic send_frame(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input int gap, input string tag);
    for (int k = 0; k < 2 * N * N; k++) begin
      push(elem(a, b, k), 1'b0);
      if (k == 2 * N * N - 2) chk({tag, "_ov_before_last"}, out_valid, 1'b0);
      if (k == 2 * N * N - 1) chk({tag, "_ov_after_last"}, out_valid, 1'b1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ack_ov"}, out_valid, 1'b0);
    chk({tag, "_ack_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        exp_a[(i * N + j) * W +: W] = (i == j) ? 8'd1 : 8'd0;
        exp_b[(i * N + j) * W +: W] = W'(i + j);
      end
    end
    tmp_a = exp_a;
    tmp_a[7:0] = 8'h5A;
    bnd_a = '0;
    bnd_a[7:0] = 8'h80;
    bnd_a[199:192] = 8'h7F;
    bnd_b = '1;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_a", A, '0);
    chk("rst_b", B, '0);
    chk("rst_err", erro_sync, 1'b0);

    // Back-to-back frame; in_first on A[0][0] at a frame start is not an error
    push(elem(exp_a, exp_b, 0), 1'b1);
    chk("f1_first_noerr", erro_sync, 1'b0);
    for (int k = 1; k < 2 * N * N; k++) begin
      push(elem(exp_a, exp_b, k), 1'b0);
      if (k == 48) chk("f1_ov_before_last", out_valid, 1'b0);
      if (k == 49) chk("f1_ov_after_last", out_valid, 1'b1);
    end
    chk("f1_a", A, exp_a);
    chk("f1_b", B, exp_b);
    chk("f1_a00", A[7:0], 8'd1);
    chk("f1_a01", A[15:8], 8'd0);
    chk("f1_a44", A[199:192], 8'd1);
    chk("f1_b00", B[7:0], 8'd0);
    chk("f1_b44", B[199:192], 8'd8);
    // Held pair ignores further input
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    chk("f1_wait_rdy", in_ready, 1'b0);
    chk("f1_wait_ov", out_valid, 1'b1);
    chk("f1_wait_a", A, exp_a);
    chk("f1_wait_b", B, exp_b);
    // No accept in the acknowledge cycle even with in_valid high
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("f1_ack_ov", out_valid, 1'b0);
    chk("f1_ack_rdy", in_ready, 1'b1);
    chk("f1_ack_a", A, exp_a);

    // Same data, valid every other cycle
    send_frame(exp_a, exp_b, 1, "f2");
    chk("f2_a", A, exp_a);
    chk("f2_b", B, exp_b);
    ack("f2");

    // Resync marker on the 31st element
    for (int k = 0; k < 30; k++) push(elem(exp_a, exp_b, k), 1'b0);
    chk("f3_no_err_yet", erro_sync, 1'b0);
    push(8'h5A, 1'b1);
    chk("f3_err_pulse", erro_sync, 1'b1);
    chk("f3_a00", A[7:0], 8'h5A);
    for (int k = 1; k < 2 * N * N; k++) begin
      push(elem(tmp_a, exp_b, k), 1'b0);
      if (k == 1) chk("f3_err_cleared", erro_sync, 1'b0);
      if (k == 48) chk("f3_ov_before_last", out_valid, 1'b0);
      if (k == 49) chk("f3_ov_after_last", out_valid, 1'b1);
    end
    chk("f3_a", A, tmp_a);
    chk("f3_b", B, exp_b);
    ack("f3");

    // Reset mid-frame discards progress
    for (int k = 0; k < 20; k++) push(elem(exp_b, exp_a, k), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("f4_rst_ov", out_valid, 1'b0);
    chk("f4_rst_rdy", in_ready, 1'b1);
    chk("f4_rst_a", A, '0);
    send_frame(exp_a, exp_b, 0, "f4");
    chk("f4_a", A, exp_a);
    chk("f4_b", B, exp_b);
    ack("f4");

    // Boundary values stored verbatim
    send_frame(bnd_a, bnd_b, 0, "f5");
    chk("f5_a00", A[7:0], 8'h80);
    chk("f5_a44", A[199:192], 8'h7F);
    chk("f5_a", A, bnd_a);
    chk("f5_b", B, bnd_b);
    ack("f5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
